logic_unit_pipe: RTL and testbench

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pkg.sv | 21 ++
 rtl/logic_unit_stage.sv | 44 ++++
 rtl/logic_unit_pipe.sv | 99 +++++++++
 tb/tb_logic_unit_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit: op encoding and parameter bounds.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_ZERO = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_NOR  = 3'b100,
    OP_NAND = 3'b101,
    OP_XNOR = 3'b110,
    OP_NOTA = 3'b111
  } op_e;

  localparam int WIDTH_DEF  = 32;
  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 64;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

endpackage

// File: rtl/logic_unit_stage.sv
// One valid/ready register slice; the payload is forced to zero whenever the slot is empty.
module logic_unit_stage
  import logic_unit_pkg::*;
#(
  parameter int PW = WIDTH_DEF + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid_i,
  input  logic [PW-1:0] up_data_i,
  input  logic          dn_ready_i,
  output logic          dn_valid_o,
  output logic [PW-1:0] dn_data_o
);

  logic          valid_q, valid_d;
  logic [PW-1:0] data_q, data_d;
  logic          load;

  assign load = !valid_q || dn_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = up_valid_i;
      data_d  = up_valid_i ? up_data_i : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with valid/ready flow control and STAGES register slices.
// Optional LOGIC_UNIT_ZERO_FLAG_EN carries a result-is-zero flag alongside the data.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("logic_unit_pipe: STAGES out of range 1..4");
  end
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("logic_unit_pipe: WIDTH out of range 1..64");
  end

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  localparam int PW = WIDTH + 1;
`else
  localparam int PW = WIDTH;
`endif

  function automatic logic [WIDTH-1:0] eval_op(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input op_e op);
    logic [WIDTH-1:0] r;
    r = '0;
    unique case (op)
      OP_ZERO: r = '0;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NOR:  r = ~(x | y);
      OP_NAND: r = ~(x & y);
      OP_XNOR: r = ~(x ^ y);
      OP_NOTA: r = ~x;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0]         res_p0;
  logic [PW-1:0]            pay_p0;
  logic [STAGES:0]          vld_p;
  logic [STAGES:0]          rdy_p;
  logic [STAGES:0][PW-1:0]  dat_p;

  assign res_p0 = eval_op(a, b, op_e'(f));

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  assign pay_p0 = {(res_p0 == '0), res_p0};
`else
  assign pay_p0 = res_p0;
`endif

  // Stage boundary: slot k feeds slot k+1; readiness is derived from occupancy
  // directly so it never chains combinationally through the slices.
  assign vld_p[0]      = in_valid;
  assign dat_p[0]      = pay_p0;
  assign rdy_p[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign rdy_p[k] = out_ready || !(&vld_p[STAGES:k+1]);

    logic_unit_stage #(.PW(PW)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid_i (vld_p[k]),
      .up_data_i  (dat_p[k]),
      .dn_ready_i (rdy_p[k+1]),
      .dn_valid_o (vld_p[k+1]),
      .dn_data_o  (dat_p[k+1])
    );
  end

  assign in_ready  = rdy_p[0];
  assign out_valid = vld_p[STAGES];

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  assign out  = dat_p[STAGES][WIDTH-1:0];
  assign zero = dat_p[STAGES][WIDTH];
`else
  assign out  = dat_p[STAGES];
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: queue-based reference model plus directed and random traffic.
module tb_logic_unit_pipe;

  localparam int W   = 32;
  localparam int STG = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, zero;
  logic [W-1:0] a, b, out;
  logic [2:0]   f;

  logic         v8, irdy1, irdy4, ov1, ov4, z1, z4;
  logic [7:0]   a8, b8, o1, o4;
  logic [2:0]   f8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] qd[$];
  int           qa[$];
  logic         exp_v;
  logic         exp_z;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W), .STAGES(STG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .f(f), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero)
  );

  logic_unit_pipe #(.WIDTH(8), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(irdy1),
    .a(a8), .b(b8), .f(f8), .out_valid(ov1), .out_ready(1'b1),
    .out(o1), .zero(z1)
  );

  logic_unit_pipe #(.WIDTH(8), .STAGES(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(irdy4),
    .a(a8), .b(b8), .f(f8), .out_valid(ov4), .out_ready(1'b1),
    .out(o4), .zero(z4)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return '0;
      3'd1:    return x & y;
      3'd2:    return x | y;
      3'd3:    return x ^ y;
      3'd4:    return ~(x | y);
      3'd5:    return ~(x & y);
      3'd6:    return ~(x ^ y);
      default: return ~x;
    endcase
  endfunction

  function automatic logic ref_zero(input logic [W-1:0] r);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    return (r == '0);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the queue holds accepted beats in order with their acceptance edge.
  // The oldest beat is visible once it has aged STG-1 edges past its capture edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      qd.delete();
      qa.delete();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out", out, 0);
      chk("rst_zero", zero, 0);
    end else begin
      exp_v = (qd.size() > 0) && (cyc - qa[0] >= STG - 1);
      chk("out_valid", out_valid, exp_v);
      chk("in_ready", in_ready, (qd.size() < STG) || out_ready);
      if (exp_v) begin
        chk("out_data", out, qd[0]);
        exp_z = ref_zero(qd[0]);
        chk("out_zero", zero, exp_z);
      end else begin
        chk("idle_out", out, 0);
        chk("idle_zero", zero, 0);
      end
      if (exp_v && out_ready) begin
        void'(qd.pop_front());
        void'(qa.pop_front());
      end
      if (in_valid && in_ready) begin
        qd.push_back(ref_op(a, b, f));
        qa.push_back(cyc + 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] sweep_exp [8];
    logic [W-1:0] got [8];
    logic         gotz [8];
    int cnt, first_n, last_n, l1, l4;

    sweep_exp[0] = 32'h0000_0000; sweep_exp[1] = 32'hF000_F000;
    sweep_exp[2] = 32'hFFF0_FFF0; sweep_exp[3] = 32'h0FF0_0FF0;
    sweep_exp[4] = 32'h000F_000F; sweep_exp[5] = 32'h0FFF_0FFF;
    sweep_exp[6] = 32'hF00F_F00F; sweep_exp[7] = 32'h0F0F_0F0F;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; f = '0;
    v8 = 1'b0; a8 = '0; b8 = '0; f8 = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out", out, 0);
    chk("reset_zero", zero, 0);
    chk("reset_in_ready", in_ready, 1);

    // Op sweep back-to-back with fixed operands.
    @(posedge clk); #1;
    cnt = 0; first_n = -1; last_n = -1;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          chk("b2b_in_ready", in_ready, 1);
          a = 32'hF0F0_F0F0; b = 32'hFF00_FF00; f = 3'(k); in_valid = 1'b1;
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int n = 0; n < 16; n++) begin
          @(negedge clk);
          if (out_valid) begin
            if (cnt == 0) first_n = n;
            last_n = n;
            if (cnt < 8) got[cnt] = out;
            cnt++;
          end
        end
      end
    join
    chk("sweep_first_latency", first_n, 2);
    chk("sweep_count", cnt, 8);
    chk("sweep_consecutive", last_n - first_n, 7);
    for (int k = 0; k < 8; k++) chk($sformatf("sweep_op%0d", k), got[k], sweep_exp[k]);

    // Backpressure: three beats while the consumer stalls.
    @(posedge clk); #1;
    out_ready = 1'b0;
    a = 32'd1; b = '0; f = 3'b010; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'd2;
    @(posedge clk); #1;
    a = 32'd3;
    chk("stall_in_ready", in_ready, 0);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      chk("stall_in_ready_hold", in_ready, 0);
      chk("stall_valid_hold", out_valid, 1);
      chk("stall_out_hold", out, 32'd1);
    end
    out_ready = 1'b1;
    cnt = 0;
    @(negedge clk);
    if (out_valid) begin got[cnt] = out; cnt++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (out_valid && cnt < 8) begin got[cnt] = out; cnt++; end
    end
    chk("stall_count", cnt, 3);
    for (int k = 0; k < 3; k++) chk($sformatf("stall_order%0d", k), got[k], k + 1);

    // Zero flag: XOR of equal operands, then OR.
    @(posedge clk); #1;
    a = 32'h1234_5678; b = 32'h1234_5678; f = 3'b011; in_valid = 1'b1;
    @(posedge clk); #1;
    f = 3'b010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (out_valid && cnt < 8) begin got[cnt] = out; gotz[cnt] = zero; cnt++; end
    end
    chk("zero_count", cnt, 2);
    chk("zero_xor_out", got[0], 0);
    chk("zero_or_out", got[1], 32'h1234_5678);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    chk("zero_xor_flag", gotz[0], 1);
`else
    chk("zero_xor_flag", gotz[0], 0);
`endif
    chk("zero_or_flag", gotz[1], 0);

    // Asynchronous reset with two beats in flight.
    @(posedge clk); #1;
    a = 32'hDEAD_BEEF; b = 32'h0; f = 3'b010; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'hCAFE_F00D;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_out", out, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("post_rst_no_stale", out_valid, 0);
    end
    chk("post_rst_in_ready", in_ready, 1);

    // Latency of the 1- and 4-stage 8-bit builds.
    @(posedge clk); #1;
    a8 = 8'hAA; b8 = 8'h0F; f8 = 3'b001; v8 = 1'b1;
    chk("s1_in_ready", irdy1, 1);
    chk("s4_in_ready", irdy4, 1);
    @(posedge clk); #1;
    v8 = 1'b0;
    l1 = 0; l4 = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (ov1 && l1 == 0) begin l1 = n; chk("s1_out", o1, 8'h0A); chk("s1_zero", z1, 0); end
      if (ov4 && l4 == 0) begin l4 = n; chk("s4_out", o4, 8'h0A); chk("s4_zero", z4, 0); end
    end
    chk("s1_latency", l1, 1);
    chk("s4_latency", l4, 4);

    // Randomized traffic with a mid-run reset; checked by the reference model.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      f         = 3'($urandom_range(0, 7));
      a         = $urandom;
      b         = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if (i == 700) begin #2 rst_n = 1'b0; end
      if (i == 703) begin #2 rst_n = 1'b1; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (STG + 3) @(negedge clk);
    chk("drain_empty", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
